// File: rtl/uart_rx.sv
// 8N1 UART receiver with held-valid/ack handshake, sticky overrun and frame-error pulse.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and drive parity_err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ena,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    // The IDLE cycle that sees the start edge is the first cycle of the half bit,
    // so START samples one count earlier than HALF_BIT-1.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 2);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic          rxMeta_q;
    logic          rxs_q;
    logic [2:0]    state_q,    state_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [2:0]    bitIdx_q,   bitIdx_d;
    logic [7:0]    shift_q,    shift_d;
    logic [7:0]    rxData_q,   rxData_d;
    logic          rxValid_q,  rxValid_d;
    logic          overrun_q,  overrun_d;
    logic          frameErr_q, frameErr_d;
    logic          bitTick;
    logic          byteGood;
`ifdef UART_RX_PARITY_EN
    logic          parityErr_q, parityErr_d;
    logic          parFail_q,   parFail_d;
`endif

    assign bitTick = (cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        rxData_d   = rxData_q;
        rxValid_d  = rxValid_q;
        overrun_d  = overrun_q;
        frameErr_d = 1'b0;
        byteGood   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityErr_d = 1'b0;
        parFail_d   = parFail_q;
`endif

        if (!ena) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bitIdx_d = '0;
`ifdef UART_RX_PARITY_EN
            parFail_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_d = START;
                        cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                        parFail_d = 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d    = '0;
                        bitIdx_d = '0;
                        state_d  = rxs_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bitTick) begin
                        cnt_d    = '0;
                        shift_d  = {rxs_q, shift_q[7:1]};
                        bitIdx_d = bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bitTick) begin
                        cnt_d   = '0;
                        state_d = STOP;
                        if ((^shift_q) != rxs_q) begin
                            parityErr_d = 1'b1;
                            parFail_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bitTick) begin
                        cnt_d = '0;
                        if (rxs_q) begin
                            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                            byteGood = !parFail_q;
`else
                            byteGood = 1'b1;
`endif
                        end else begin
                            frameErr_d = 1'b1;
                            state_d    = WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A completing byte takes priority over a simultaneous acknowledge.
        if (rxValid_q && rx_ack) begin
            rxValid_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (byteGood) begin
            if (!rxValid_q || rx_ack) begin
                rxData_d  = shift_q;
                rxValid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxMeta_q   <= 1'b1;
            rxs_q      <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
            parFail_q   <= 1'b0;
`endif
        end else begin
            rxMeta_q   <= rx;
            rxs_q      <= rxMeta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            parityErr_q <= parityErr_d;
            parFail_q   <= parFail_d;
`endif
        end
    end

    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parityErr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8; inputs change and outputs are sampled on negedges.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clock;
    logic       reset;
    logic       ena;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int passCount;
    int checkCount;
    int frameErrCount;
    int parityErrCount;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .ena       (ena),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count cycles in which the one-shot error flags are high.
    always @(negedge clock) begin
        if (frame_err === 1'b1) frameErrCount <= frameErrCount + 1;
        if (parity_err === 1'b1) parityErrCount <= parityErrCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount = checkCount + 1;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives start, data (LSB first), optional parity, then leaves rx at the stop value.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic withParity, input logic parityBit);
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitCycles(CPB);
        end
        if (withParity) begin
            rx = parityBit;
            waitCycles(CPB);
        end
        rx = stopBit;
    endtask

    task automatic pulseAck();
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
    endtask

    initial begin
        passCount      = 0;
        checkCount     = 0;
        frameErrCount  = 0;
        parityErrCount = 0;
        reset  = 1'b1;
        ena    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        waitCycles(3);

        checkOutput("reset_data",   rx_data,    8'h00);
        checkOutput("reset_valid",  rx_valid,   1'b0);
        checkOutput("reset_busy",   rx_busy,    1'b0);
        checkOutput("reset_ferr",   frame_err,  1'b0);
        checkOutput("reset_ovr",    overrun,    1'b0);
        checkOutput("reset_perr",   parity_err, 1'b0);
        reset = 1'b0;
        waitCycles(5);

        // Reset asserted in the middle of the data bits.
        rx = 1'b0;
        waitCycles(CPB + 20);
        checkOutput("midframe_busy", rx_busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_busy",  rx_busy,  1'b0);
        checkOutput("async_rst_valid", rx_valid, 1'b0);
        checkOutput("async_rst_data",  rx_data,  8'h00);
        @(negedge clock);
        rx    = 1'b1;
        reset = 1'b0;
        waitCycles(100);
        checkOutput("post_rst_valid", rx_valid, 1'b0);
        checkOutput("post_rst_busy",  rx_busy,  1'b0);

        // 0xA5: rx_valid must rise exactly 78 edges after the falling edge.
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        checkOutput("a5_valid_early", rx_valid, 1'b0);
        waitCycles(1);
        checkOutput("a5_valid_on_time", rx_valid, 1'b1);
        checkOutput("a5_data", rx_data, 8'hA5);
        waitCycles(20);
        checkOutput("a5_valid_held", rx_valid, 1'b1);
        pulseAck();
        checkOutput("a5_ack_clears", rx_valid, 1'b0);
        checkOutput("a5_data_kept", rx_data, 8'hA5);

        // Short low glitch is a false start.
        waitCycles(10);
        rx = 1'b0;
        waitCycles(3);
        rx = 1'b1;
        checkOutput("glitch_busy_pulse", rx_busy, 1'b1);
        waitCycles(5);
        checkOutput("glitch_busy_done", rx_busy, 1'b0);
        waitCycles(90);
        checkOutput("glitch_no_valid", rx_valid, 1'b0);
        checkOutput("glitch_no_ferr", frameErrCount, 0);

        // Bad stop bit followed by a long break, then a good frame.
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        waitCycles(CPB + 20);
        rx = 1'b1;
        waitCycles(12);
        checkOutput("ferr_one_pulse", frameErrCount, 1);
        checkOutput("ferr_no_valid", rx_valid, 1'b0);
        checkOutput("ferr_idle", rx_busy, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        waitCycles(CPB);
        checkOutput("after_break_valid", rx_valid, 1'b1);
        checkOutput("after_break_data", rx_data, 8'h5A);
        checkOutput("after_break_ferr", frameErrCount, 1);
        pulseAck();
        waitCycles(4);

        // Overrun: second byte dropped while the first is unacknowledged.
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
        waitCycles(CPB + 4);
        checkOutput("b11_data", rx_data, 8'h11);
        checkOutput("b11_no_ovr", overrun, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
        waitCycles(CPB + 4);
        checkOutput("ovr_data_kept", rx_data, 8'h11);
        checkOutput("ovr_set", overrun, 1'b1);
        checkOutput("ovr_valid", rx_valid, 1'b1);
        pulseAck();
        checkOutput("ovr_ack_valid", rx_valid, 1'b0);
        checkOutput("ovr_ack_clear", overrun, 1'b0);
        waitCycles(4);

        // Ack raised during the stop-sample cycle of 0x33.
        applyStimulus(8'h33, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        pulseAck();
        checkOutput("b33_data", rx_data, 8'h33);
        checkOutput("b33_valid", rx_valid, 1'b1);
        checkOutput("b33_no_ovr", overrun, 1'b0);
        waitCycles(6);

        // New byte beats a simultaneous ack while a byte is already held.
        applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
        waitCycles(5);
        pulseAck();
        checkOutput("b44_data", rx_data, 8'h44);
        checkOutput("b44_valid", rx_valid, 1'b1);
        checkOutput("b44_no_ovr", overrun, 1'b0);
        waitCycles(6);

        // Dropping ena mid-frame aborts quietly; the held byte survives.
        rx = 1'b0;
        waitCycles(CPB + 12);
        ena = 1'b0;
        waitCycles(2);
        checkOutput("ena_abort_busy", rx_busy, 1'b0);
        rx = 1'b1;
        waitCycles(2);
        ena = 1'b1;
        waitCycles(100);
        checkOutput("ena_busy_idle", rx_busy, 1'b0);
        checkOutput("ena_data_held", rx_data, 8'h44);
        checkOutput("ena_valid_held", rx_valid, 1'b1);
        checkOutput("ena_no_ferr", frameErrCount, 1);
        pulseAck();
        waitCycles(4);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity requires a 1.
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
        waitCycles(CPB + 4);
        checkOutput("par_bad_pulse", parityErrCount, 1);
        checkOutput("par_bad_no_valid", rx_valid, 1'b0);
        applyStimulus(8'h07, 1'b1, 1'b1, 1'b1);
        waitCycles(CPB + 4);
        checkOutput("par_ok_valid", rx_valid, 1'b1);
        checkOutput("par_ok_data", rx_data, 8'h07);
        checkOutput("par_ok_no_pulse", parityErrCount, 1);
`else
        checkOutput("no_parity_pulses", parityErrCount, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver: 8N1 frames, LSB first, line idle high; the receive-side counterpart of the design's UART transmitter. Recovers bytes from a pin for host command and operand loading. Presents each byte on a held-valid/ack handshake, with sticky overrun and one-cycle frame-error flags. Sits between a uio input pin and the core FSM/register path.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600 baud); minimum 4.
HALF_BIT, CLKS_PER_BIT/2, derived (localparam), cycles from start-edge detect to mid-start sample.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ena  in  1  block enable; low aborts any frame in progress
rx  in  1  serial input pin, asynchronous to clock, idle high
rx_ack  in  1  consumer acknowledge; one-cycle pulse clears rx_valid/overrun
rx_data  out  8  last accepted byte
rx_valid  out  1  byte available; held until rx_ack
rx_busy  out  1  high while state != IDLE
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  sticky: a byte completed while rx_valid=1
parity_err  out  1  one-cycle pulse on parity mismatch (tied 0 without macro)

Behaviour:
- Reset (async): rx_data=0x00; rx_valid, rx_busy, frame_err, overrun, parity_err = 0; synchronizer flops = 1; state=IDLE; counters=0.
- rx passes through 2-flop synchronizer (reset value 1); all logic uses synced signal rxs. Adds 2 cycles latency.
- States: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
- IDLE: when rxs=0, enter START with cycle counter=0.
- START: count to HALF_BIT-1, then sample rxs. If 1: false start, return to IDLE with no flags. If 0: counter=0, bit index=0, enter DATA.
- DATA: sample when counter==CLKS_PER_BIT-1, then reset counter. Shift sampled bit in LSB first. After bit index 7, enter STOP (or PARITY).
- STOP: sample at counter==CLKS_PER_BIT-1.
  - rxs=1: the byte is good; return to IDLE.
  - rxs=0: pulse frame_err for 1 cycle, drop the byte, enter WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. Prevents a break condition being decoded as 0x00 frames.
- Good byte, registered the cycle after the stop sample:
  - rx_valid=0, or rx_ack=1 that cycle: rx_data <= byte and rx_valid <= 1. No overrun; the new byte wins over ack.
  - rx_valid=1 and rx_ack=0: rx_data is kept (old byte preserved), the new byte is dropped, and overrun <= 1.
- rx_ack=1 with no new byte: rx_valid <= 0 and overrun <= 0 next edge. rx_ack while rx_valid=0 has no effect.
- Timing: stop sample occurs HALF_BIT-1 + 9*CLKS_PER_BIT cycles after the IDLE cycle that first sees rxs=0. rx_valid rises 1 cycle later.
- ena=0: state returns to IDLE, counters cleared, no flags raised. rx_data, rx_valid and overrun hold, and rx_ack is still honoured. Receiving resumes on the next falling edge after ena=1.
- rx_busy=0 only in IDLE.
- Counters are sized by $clog2(CLKS_PER_BIT) and never wrap within a bit.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP samples one even-parity bit (frame 8E1).
  - Mismatch (XOR of data bits != parity bit): parity_err pulses 1 cycle at the parity sample. The frame continues through STOP, then the byte is dropped; rx_valid and overrun are unaffected.
  - Stop-sample timing shifts by +CLKS_PER_BIT.
- Undefined: no PARITY state and 8N1 framing only. The parity_err port exists, tied 0.

Test Plan:
1. Assert reset mid-frame (rx=0 during DATA) -> all outputs 0 immediately, state IDLE. After release with rx=1 idle, nothing is received.
2. CLKS_PER_BIT=8; send 0xA5 (8N1), rx_ack=0 -> rx_valid rises exactly 2+3+72+1 cycles after the falling edge on rx, with rx_data=0xA5. It stays high 20 cycles until a 1-cycle rx_ack, then clears next edge.
3. Drive rx low for 3 cycles, then high (glitch < HALF_BIT after sync) -> no rx_valid, no frame_err; rx_busy pulses, then returns to 0.
4. Send 0x3C with stop bit 0, hold rx low 20 more cycles, then send 0x5A correctly -> one frame_err pulse, no rx_valid for 0x3C, no spurious 0x00, then rx_data=0x5A with rx_valid=1.
5. Send 0x11 then 0x22 with no ack -> rx_data=0x11, overrun=1. rx_ack clears both. Next, send 0x33 and pulse ack the same cycle it completes -> rx_data=0x33, rx_valid=1, overrun=0.
6. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (correct is 1) -> parity_err pulse, rx_valid stays 0. Send 0x07 with parity bit 1 -> rx_data=0x07, rx_valid=1.
